spi_slave_shift: RTL and testbench

SPI responder (slave side) for our SPI master core. Oversamples the incoming sclk/ss_n/mosi pins in the wb_clk domain, deserialises MOSI into CHAR_LEN-bit words and serialises a host-supplied word onto MISO. Supports all four CPOL/CPHA modes. Gives the local host a one-word TX buffer with a valid/ready handshake and a one-cycle RX strobe.

---
 rtl/spi_slave_shift.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_slave_shift.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_shift.sv
// spi_slave_shift: SPI responder clocked entirely by wb_clk.
// The sclk, ss_n and mosi pins are oversampled through 2-flop synchronisers.
// MOSI is deserialised into CHAR_LEN-bit words, and a host word is serialised onto MISO.
// The host side has a one-word TX buffer (valid/ready) and a one-cycle RX strobe.
// Optional build macro SPI_SLAVE_LSB_FIRST_EN: when defined, both shift
// registers run LSB-first; otherwise they run MSB-first.
module spi_slave_shift #(
   parameter int CHAR_LEN = 8,
   parameter int CNT_W    = 6
) (
   input  logic                wb_clk,
   input  logic                wb_reset_n,
   input  logic                cpol,
   input  logic                cpha,
   input  logic                sclk,
   input  logic                ss_n,
   input  logic                mosi,
   output logic                miso,
   output logic                miso_oe,
   input  logic [CHAR_LEN-1:0] tx_data,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic                tx_underrun,
   output logic [CHAR_LEN-1:0] rx_data,
   output logic                rx_valid,
   output logic                busy
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(CHAR_LEN);
   localparam logic [CNT_W-1:0]    CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]    CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CHAR_LEN-1:0] WORD_ZERO = {CHAR_LEN{1'b0}};

   // Bit presented on MISO for a given transmit shift register.
   function automatic logic tx_out_bit(input logic [CHAR_LEN-1:0] sr);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      return sr[0];
`else
      return sr[CHAR_LEN-1];
`endif
   endfunction

   // Advance the transmit register by one bit, zero fill.
   function automatic logic [CHAR_LEN-1:0] tx_advance(input logic [CHAR_LEN-1:0] sr);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      return {1'b0, sr[CHAR_LEN-1:1]};
`else
      return {sr[CHAR_LEN-2:0], 1'b0};
`endif
   endfunction

   // Insert one received bit into the receive register.
   function automatic logic [CHAR_LEN-1:0] rx_insert(input logic [CHAR_LEN-1:0] sr,
                                                     input logic            din);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      return {din, sr[CHAR_LEN-1:1]};
`else
      return {sr[CHAR_LEN-2:0], din};
`endif
   endfunction

   // Synchroniser stages plus registered copies for edge detection.
   logic sclk_meta_q, sclk_meta_d, sclk_sync_q, sclk_sync_d, sclk_prev_q, sclk_prev_d;
   logic ss_meta_q, ss_meta_d, ss_sync_q, ss_sync_d, ss_prev_q, ss_prev_d;
   logic mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;

   // Core state.
   state_e              state_q, state_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CHAR_LEN-1:0] tx_sr_q, tx_sr_d;
   logic [CHAR_LEN-1:0] rx_sr_q, rx_sr_d;
   logic [CHAR_LEN-1:0] tx_buf_q, tx_buf_d;
   logic                buf_full_q, buf_full_d;

   // Registered outputs.
   logic [CHAR_LEN-1:0] rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                tx_ready_q, tx_ready_d;
   logic                tx_underrun_q, tx_underrun_d;
   logic                miso_q, miso_d;
   logic                miso_oe_q, miso_oe_d;
   logic                busy_q, busy_d;

   // Decoded pin events.
   logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
   logic ss_fall, ss_rise, host_write, load_tx;
   logic [CNT_W-1:0] cnt_inc;

   assign sclk_rise   = sclk_sync_q & ~sclk_prev_q;
   assign sclk_fall   = ~sclk_sync_q & sclk_prev_q;
   assign lead_edge   = cpol ? sclk_fall : sclk_rise;
   assign trail_edge  = cpol ? sclk_rise : sclk_fall;
   assign sample_edge = cpha ? trail_edge : lead_edge;
   assign shift_edge  = cpha ? lead_edge : trail_edge;
   assign ss_fall     = ~ss_sync_q & ss_prev_q;
   assign ss_rise     = ss_sync_q & ~ss_prev_q;
   assign host_write  = tx_valid & tx_ready_q;
   assign cnt_inc     = bit_cnt_q + CNT_ONE;

   // Next-state logic: synchronisers, FSM, shift registers, TX buffer and outputs.
   always_comb begin
      sclk_meta_d   = sclk;
      sclk_sync_d   = sclk_meta_q;
      sclk_prev_d   = sclk_sync_q;
      ss_meta_d     = ss_n;
      ss_sync_d     = ss_meta_q;
      ss_prev_d     = ss_sync_q;
      mosi_meta_d   = mosi;
      mosi_sync_d   = mosi_meta_q;
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      tx_sr_d       = tx_sr_q;
      rx_sr_d       = rx_sr_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      load_tx       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               state_d   = ST_ACTIVE;
               bit_cnt_d = CNT_ZERO;
               load_tx   = 1'b1;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (ss_rise) begin
               // Deselect wins over a coincident sample; the partial word is dropped.
               state_d   = ST_IDLE;
               bit_cnt_d = CNT_ZERO;
               rx_sr_d   = WORD_ZERO;
            end else if (sample_edge) begin
               rx_sr_d = rx_insert(rx_sr_q, mosi_sync_q);
               if (cnt_inc == CNT_LAST) begin
                  rx_data_d  = rx_sr_d;
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = CNT_ZERO;
                  load_tx    = 1'b1;
               end else begin
                  bit_cnt_d  = cnt_inc;
               end
            end else if (shift_edge && (bit_cnt_q != CNT_ZERO)) begin
               // A shift edge before the first sample of a word is ignored so
               // the first bit stays on MISO.
               tx_sr_d = tx_advance(tx_sr_q);
            end else begin
               tx_sr_d = tx_sr_q;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = CNT_ZERO;
         end
      endcase

      // Word load: take the buffered word, or zeros when the buffer is empty.
      if (load_tx) begin
         tx_sr_d = buf_full_q ? tx_buf_q : WORD_ZERO;
      end else begin
         tx_sr_d = tx_sr_d;
      end
      tx_underrun_d = load_tx & ~buf_full_q;

      // A host write fills the buffer even when a load drains it in the same cycle.
      if (host_write) begin
         tx_buf_d   = tx_data;
         buf_full_d = 1'b1;
      end else if (load_tx) begin
         tx_buf_d   = tx_buf_q;
         buf_full_d = 1'b0;
      end else begin
         tx_buf_d   = tx_buf_q;
         buf_full_d = buf_full_q;
      end

      tx_ready_d = ~buf_full_d;
      miso_d     = tx_out_bit(tx_sr_d);
      miso_oe_d  = (state_d == ST_ACTIVE);
      busy_d     = (state_d == ST_ACTIVE);
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge wb_clk) begin
      if (!wb_reset_n) begin
         sclk_meta_q   <= cpol;
         sclk_sync_q   <= cpol;
         sclk_prev_q   <= cpol;
         ss_meta_q     <= 1'b1;
         ss_sync_q     <= 1'b1;
         ss_prev_q     <= 1'b1;
         mosi_meta_q   <= 1'b0;
         mosi_sync_q   <= 1'b0;
         state_q       <= ST_IDLE;
         bit_cnt_q     <= CNT_ZERO;
         tx_sr_q       <= WORD_ZERO;
         rx_sr_q       <= WORD_ZERO;
         tx_buf_q      <= WORD_ZERO;
         buf_full_q    <= 1'b0;
         rx_data_q     <= WORD_ZERO;
         rx_valid_q    <= 1'b0;
         tx_ready_q    <= 1'b1;
         tx_underrun_q <= 1'b0;
         miso_q        <= 1'b0;
         miso_oe_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         sclk_meta_q   <= sclk_meta_d;
         sclk_sync_q   <= sclk_sync_d;
         sclk_prev_q   <= sclk_prev_d;
         ss_meta_q     <= ss_meta_d;
         ss_sync_q     <= ss_sync_d;
         ss_prev_q     <= ss_prev_d;
         mosi_meta_q   <= mosi_meta_d;
         mosi_sync_q   <= mosi_sync_d;
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         tx_sr_q       <= tx_sr_d;
         rx_sr_q       <= rx_sr_d;
         tx_buf_q      <= tx_buf_d;
         buf_full_q    <= buf_full_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         tx_ready_q    <= tx_ready_d;
         tx_underrun_q <= tx_underrun_d;
         miso_q        <= miso_d;
         miso_oe_q     <= miso_oe_d;
         busy_q        <= busy_d;
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = miso_oe_q;
   assign tx_ready    = tx_ready_q;
   assign tx_underrun = tx_underrun_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_shift.sv
// Directed bench for spi_slave_shift: behavioural SPI master, host-side
// writer, and pulse monitors on rx_valid / tx_underrun.
module tb_spi_slave_shift;

   localparam int CL = 8;
   localparam int H  = 4;   // sclk half-period in wb_clk cycles

   logic          wb_clk = 1'b0;
   logic          wb_reset_n, cpol, cpha, sclk, ss_n, mosi;
   logic          miso, miso_oe, tx_ready, tx_underrun, rx_valid, busy, tx_valid;
   logic [CL-1:0] tx_data, rx_data;

   int errors = 0;
   int checks = 0;
   int rx_cnt = 0;
   int urun_cnt = 0;
   logic [CL-1:0] rx_hist[$];

   spi_slave_shift #(.CHAR_LEN(CL), .CNT_W(6)) dut (
      .wb_clk(wb_clk), .wb_reset_n(wb_reset_n), .cpol(cpol), .cpha(cpha),
      .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_underrun(tx_underrun), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
   );

   always #5 wb_clk = ~wb_clk;

   // Count strobe cycles; a pulse longer than one cycle is counted more than once.
   always @(negedge wb_clk) begin
      if (rx_valid === 1'b1) begin
         rx_cnt++;
         rx_hist.push_back(rx_data);
      end
      if (tx_underrun === 1'b1) urun_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic clk(input int n);
      repeat (n) @(negedge wb_clk);
   endtask

   function automatic int bidx(input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      return i;
`else
      return CL - 1 - i;
`endif
   endfunction

   task automatic set_mode(input logic p, input logic h);
      cpol = p; cpha = h; sclk = p; mosi = 1'b0;
      clk(6);
   endtask

   // Master shifts nbits of mo out and collects MISO at its sample edges.
   task automatic spi_word(input logic [CL-1:0] mo, input int nbits, output logic [CL-1:0] mi);
      mi = '0;
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            mosi = mo[bidx(i)];
            clk(H);
            mi[bidx(i)] = miso;
            sclk = ~sclk;
            clk(H);
            sclk = ~sclk;
         end else begin
            sclk = ~sclk;
            mosi = mo[bidx(i)];
            clk(H);
            mi[bidx(i)] = miso;
            sclk = ~sclk;
            clk(H);
         end
      end
   endtask

   task automatic host_write(input logic [CL-1:0] d);
      int n = 0;
      while (tx_ready !== 1'b1 && n < 100) begin clk(1); n++; end
      checks++;
      if (tx_ready !== 1'b1) begin
         errors++; $display("FAIL host_wait: tx_ready=%b required 1 within 100 cycles", tx_ready);
      end
      tx_valid = 1'b1; tx_data = d;
      clk(1);
      tx_valid = 1'b0;
      checks++;
      if (tx_ready !== 1'b0) begin
         errors++; $display("FAIL tx_ready_drop: got %b required 0", tx_ready);
      end
   endtask

   task automatic test_reset();
      wb_reset_n = 1'b0; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; ss_n = 1'b1;
      mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
      clk(3);
      checks++;
      if ({miso, miso_oe, rx_valid, tx_ready, tx_underrun, busy} !== 6'b000100) begin
         errors++; $display("FAIL reset_flags: got %b required 000100",
                            {miso, miso_oe, rx_valid, tx_ready, tx_underrun, busy});
      end
      checks++;
      if (rx_data !== 8'h00) begin
         errors++; $display("FAIL reset_rx_data: got %h required 00", rx_data);
      end
      wb_reset_n = 1'b1;
      clk(4);
   endtask

   task automatic test_mode0();
      logic [CL-1:0] got;
      int r0, u0;
      set_mode(1'b0, 1'b0);
      r0 = rx_cnt; u0 = urun_cnt;
      host_write(8'hA5);
      ss_n = 1'b0; clk(8);
      checks++;
      if ({busy, miso_oe, tx_ready} !== 3'b111) begin
         errors++; $display("FAIL m0_select: busy/oe/ready got %b required 111", {busy, miso_oe, tx_ready});
      end
      checks++;
      if (urun_cnt - u0 !== 0) begin
         errors++; $display("FAIL m0_no_underrun: got %0d required 0", urun_cnt - u0);
      end
      spi_word(8'h3C, 8, got);
      ss_n = 1'b1; clk(8);
      checks++;
      if (got !== 8'hA5) begin
         errors++; $display("FAIL m0_miso: got %h required a5", got);
      end
      checks++;
      if (rx_cnt - r0 !== 1 || rx_hist[$] !== 8'h3C) begin
         errors++; $display("FAIL m0_rx: pulses %0d data %h required 1 and 3c", rx_cnt - r0, rx_hist[$]);
      end
      checks++;
      if (urun_cnt - u0 !== 1 || busy !== 1'b0) begin
         errors++; $display("FAIL m0_end: underruns %0d busy %b required 1 and 0", urun_cnt - u0, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [CL-1:0] g1, g2;
      int r0, u0;
      set_mode(1'b1, 1'b1);
      r0 = rx_cnt; u0 = urun_cnt;
      host_write(8'h55);
      ss_n = 1'b0; clk(8);
      host_write(8'hAA);
      spi_word(8'h81, 8, g1);
      checks++;
      if (urun_cnt - u0 !== 0) begin
         errors++; $display("FAIL b2b_first_reload: underruns %0d required 0", urun_cnt - u0);
      end
      spi_word(8'h7E, 8, g2);
      ss_n = 1'b1; clk(8);
      checks++;
      if (g1 !== 8'h55 || g2 !== 8'hAA) begin
         errors++; $display("FAIL b2b_miso: got %h %h required 55 aa", g1, g2);
      end
      checks++;
      if (rx_cnt - r0 !== 2) begin
         errors++; $display("FAIL b2b_rx_count: got %0d required 2", rx_cnt - r0);
      end else if (rx_hist[rx_hist.size()-2] !== 8'h81 || rx_hist[rx_hist.size()-1] !== 8'h7E) begin
         errors++; $display("FAIL b2b_rx_data: got %h %h required 81 7e",
                            rx_hist[rx_hist.size()-2], rx_hist[rx_hist.size()-1]);
      end
      checks++;
      if (urun_cnt - u0 !== 1) begin
         errors++; $display("FAIL b2b_underrun: got %0d required 1", urun_cnt - u0);
      end
   endtask

   task automatic test_underrun();
      logic [CL-1:0] got;
      int r0, u0;
      set_mode(1'b0, 1'b0);
      r0 = rx_cnt; u0 = urun_cnt;
      ss_n = 1'b0; clk(8);
      checks++;
      if (urun_cnt - u0 !== 1) begin
         errors++; $display("FAIL ur_pulse: got %0d cycles required 1", urun_cnt - u0);
      end
      spi_word(8'h96, 8, got);
      ss_n = 1'b1; clk(8);
      checks++;
      if (got !== 8'h00) begin
         errors++; $display("FAIL ur_miso: got %h required 00", got);
      end
      checks++;
      if (rx_cnt - r0 !== 1 || rx_hist[$] !== 8'h96) begin
         errors++; $display("FAIL ur_rx: pulses %0d data %h required 1 and 96", rx_cnt - r0, rx_hist[$]);
      end
   endtask

   task automatic test_abort();
      logic [CL-1:0] got;
      int r0;
      set_mode(1'b0, 1'b0);
      r0 = rx_cnt;
      host_write(8'h11);
      ss_n = 1'b0; clk(8);
      host_write(8'h3E);
      spi_word(8'hA0, 5, got);
      ss_n = 1'b1;
      clk(2);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL abort_busy_hold: got %b required 1", busy);
      end
      clk(1);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL abort_busy_drop: got %b required 0", busy);
      end
      clk(5);
      checks++;
      if (rx_cnt - r0 !== 0) begin
         errors++; $display("FAIL abort_no_rx: got %0d pulses required 0", rx_cnt - r0);
      end
      ss_n = 1'b0; clk(8);
      spi_word(8'hC3, 8, got);
      ss_n = 1'b1; clk(8);
      checks++;
      if (got !== 8'h3E) begin
         errors++; $display("FAIL abort_kept_buf: got %h required 3e", got);
      end
      checks++;
      if (rx_cnt - r0 !== 1 || rx_hist[$] !== 8'hC3) begin
         errors++; $display("FAIL abort_rx: pulses %0d data %h required 1 and c3", rx_cnt - r0, rx_hist[$]);
      end
   endtask

   task automatic test_reset_mid();
      logic [CL-1:0] got;
      int r0;
      set_mode(1'b0, 1'b0);
      host_write(8'h5A);
      ss_n = 1'b0; clk(8);
      host_write(8'h77);
      spi_word(8'hF0, 3, got);
      wb_reset_n = 1'b0;
      clk(1);
      checks++;
      if ({miso, miso_oe, rx_valid, tx_ready, tx_underrun, busy} !== 6'b000100) begin
         errors++; $display("FAIL midreset_flags: got %b required 000100",
                            {miso, miso_oe, rx_valid, tx_ready, tx_underrun, busy});
      end
      checks++;
      if (rx_data !== 8'h00) begin
         errors++; $display("FAIL midreset_rx_data: got %h required 00", rx_data);
      end
      wb_reset_n = 1'b1; ss_n = 1'b1; sclk = 1'b0;
      clk(6);
      r0 = rx_cnt;
      host_write(8'h96);
      ss_n = 1'b0; clk(8);
      spi_word(8'h69, 8, got);
      ss_n = 1'b1; clk(8);
      checks++;
      if (got !== 8'h96) begin
         errors++; $display("FAIL midreset_miso: got %h required 96", got);
      end
      checks++;
      if (rx_cnt - r0 !== 1 || rx_hist[$] !== 8'h69) begin
         errors++; $display("FAIL midreset_rx: pulses %0d data %h required 1 and 69", rx_cnt - r0, rx_hist[$]);
      end
   endtask

   task automatic test_mode1();
      logic [CL-1:0] got;
      logic          first_exp;
`ifdef SPI_SLAVE_LSB_FIRST_EN
      first_exp = 1'b1;
`else
      first_exp = 1'b0;
`endif
      set_mode(1'b0, 1'b1);
      host_write(8'h01);
      ss_n = 1'b0; clk(8);
      spi_word(8'h01, 8, got);
      ss_n = 1'b1; clk(8);
      checks++;
      if (got[bidx(0)] !== first_exp) begin
         errors++; $display("FAIL m1_first_bit: got %b required %b", got[bidx(0)], first_exp);
      end
      checks++;
      if (got !== 8'h01) begin
         errors++; $display("FAIL m1_miso: got %h required 01", got);
      end
      checks++;
      if (rx_hist[$] !== 8'h01) begin
         errors++; $display("FAIL m1_rx: got %h required 01", rx_hist[$]);
      end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_reset_mid();
      test_mode1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
